// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, WIDTH data bits LSB first, optional even
// parity, stop bit. Sampling is qualified by the en bit strobe.
module serial_frame_rx #(
    parameter int WIDTH     = 4,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             en,
    output logic [WIDTH-1:0] dout,
    output logic             dvalid,
    output logic             ferr,
    output logic             perr,
    output logic             busy
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, HUNT} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic [WIDTH-1:0]  dout_q, dout_d;
    logic              xor_q, xor_d;
    logic              pbad_q, pbad_d;
    logic              dvalid_q, dvalid_d;
    logic              ferr_q, ferr_d;
    logic              perr_q, perr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shreg_q  <= '0;
            dout_q   <= '0;
            xor_q    <= 1'b0;
            pbad_q   <= 1'b0;
            dvalid_q <= 1'b0;
            ferr_q   <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shreg_q  <= shreg_d;
            dout_q   <= dout_d;
            xor_q    <= xor_d;
            pbad_q   <= pbad_d;
            dvalid_q <= dvalid_d;
            ferr_q   <= ferr_d;
            perr_q   <= perr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shreg_d  = shreg_q;
        dout_d   = dout_q;
        xor_d    = xor_q;
        pbad_d   = pbad_q;
        dvalid_d = 1'b0;
        ferr_d   = 1'b0;
        perr_d   = 1'b0;
        if (en) begin
            case (state_q)
                IDLE: begin
                    if (!sin) begin
                        state_d = DATA;
                        cnt_d   = '0;
                        xor_d   = 1'b0;
                        pbad_d  = 1'b0;
                    end
                end
                DATA: begin
                    shreg_d = {sin, shreg_q[WIDTH-1:1]};
                    xor_d   = xor_q ^ sin;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == LAST) state_d = PARITY_EN ? PARITY : STOP;
                end
                PARITY: begin
                    // Even parity: data XOR parity bit must come out 0.
                    pbad_d  = xor_q ^ sin;
                    state_d = STOP;
                end
                STOP: begin
                    if (!sin) begin
                        ferr_d  = 1'b1;
                        state_d = HUNT;
                    end else begin
                        if (pbad_q) begin
                            perr_d = 1'b1;
                        end else begin
                            dout_d   = shreg_q;
                            dvalid_d = 1'b1;
                        end
                        state_d = IDLE;
                    end
                end
                HUNT: begin
                    // Break on the line: wait for it to return high before rearming.
                    if (sin) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign dout   = dout_q;
    assign dvalid = dvalid_q;
    assign ferr   = ferr_q;
    assign perr   = perr_q;
    assign busy   = (state_q == DATA) || (state_q == PARITY) || (state_q == STOP);
endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx: frame-level model predicts per-cycle outputs,
// plus literal checks on the frame results.
module tb_serial_frame_rx;
    logic       clk = 1'b0;
    logic       rst, sin, en;
    logic [3:0] dout;
    logic       dvalid, ferr, perr, busy;

    int tests = 0, fails = 0;
    int cycle = 0, dv_cnt = 0, fe_cnt = 0, pe_cnt = 0, busy_cnt = 0;
    int last_dv = 0, dv_gap = 0, div = 1;
    logic [3:0] exp_dout = 4'h0;
    int s_dv, s_fe, s_pe, s_busy;

    serial_frame_rx #(.WIDTH(4), .PARITY_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .sin(sin), .en(en), .dout(dout),
        .dvalid(dvalid), .ferr(ferr), .perr(perr), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cycle, act, req);
        end
    endtask

    // One clk cycle: drive, let the edge happen, check the model's prediction.
    task automatic step(input logic r, input logic s, input logic e, input logic e_busy,
                        input logic e_dv, input logic e_fe, input logic e_pe,
                        input logic upd, input logic [3:0] nd);
        rst = r; sin = s; en = e;
        @(posedge clk);
        @(negedge clk);
        cycle++;
        if (r) exp_dout = 4'h0;
        else if (upd) exp_dout = nd;
        chk("dout", 32'(dout), 32'(exp_dout));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("dvalid", 32'(dvalid), 32'(e_dv));
        chk("ferr", 32'(ferr), 32'(e_fe));
        chk("perr", 32'(perr), 32'(e_pe));
        if (dvalid === 1'b1) begin
            dv_cnt++;
            dv_gap  = cycle - last_dv;
            last_dv = cycle;
        end
        if (ferr === 1'b1) fe_cnt++;
        if (perr === 1'b1) pe_cnt++;
        if (busy === 1'b1) busy_cnt++;
    endtask

    // One serial bit: a sampled cycle followed by div-1 unsampled cycles.
    task automatic sbit(input logic b, input logic e_busy, input logic e_dv, input logic e_fe,
                        input logic e_pe, input logic upd, input logic [3:0] nd);
        step(1'b0, b, 1'b1, e_busy, e_dv, e_fe, e_pe, upd, nd);
        for (int k = 1; k < div; k++)
            step(1'b0, b, 1'b0, e_busy, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    endtask

    // Whole frame; outcome derived from the frame rules, not the receiver's internals.
    task automatic frame(input logic [3:0] w, input bit flip_par, input bit stop);
        logic p;
        bit   good;
        p    = (^w) ^ flip_par;
        good = stop && !flip_par;
        sbit(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        for (int i = 0; i < 4; i++) sbit(w[i], 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        sbit(p, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        sbit(stop, 1'b0, good, !stop, stop && flip_par, good, w);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) sbit(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    endtask

    task automatic do_reset;
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    endtask

    task automatic snap;
        s_dv = dv_cnt; s_fe = fe_cnt; s_pe = pe_cnt; s_busy = busy_cnt;
    endtask

    initial begin
        rst = 1'b1; sin = 1'b1; en = 1'b0;
        do_reset;
        chk("reset_dout", 32'(dout), 32'h0);
        idle(2);

        // Good frame 1011, parity 1
        snap;
        frame(4'b1011, 1'b0, 1'b1);
        idle(2);
        chk("t1_dout", 32'(dout), 32'hb);
        chk("t1_dvalid_count", 32'(dv_cnt - s_dv), 32'd1);
        chk("t1_busy_cycles", 32'(busy_cnt - s_busy), 32'd6);

        // Parity error from a fresh reset: dout stays 0
        do_reset;
        snap;
        frame(4'b1011, 1'b1, 1'b1);
        idle(2);
        chk("t2_perr_count", 32'(pe_cnt - s_pe), 32'd1);
        chk("t2_dvalid_count", 32'(dv_cnt - s_dv), 32'd0);
        chk("t2_dout", 32'(dout), 32'h0);

        // Framing error then 20-cycle break, then release and a new frame
        frame(4'b1011, 1'b0, 1'b1);
        snap;
        frame(4'b0110, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) sbit(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        idle(2);
        chk("t3_ferr_count", 32'(fe_cnt - s_fe), 32'd1);
        chk("t3_other_pulses", 32'((dv_cnt - s_dv) + (pe_cnt - s_pe)), 32'd0);
        chk("t3_dout_held", 32'(dout), 32'hb);
        frame(4'b0110, 1'b0, 1'b1);
        idle(1);
        chk("t3_recover_dout", 32'(dout), 32'h6);

        // Slow strobe: en every 4th clk
        div = 4;
        idle(1);
        snap;
        frame(4'b0101, 1'b0, 1'b1);
        idle(1);
        chk("t4_dout", 32'(dout), 32'h5);
        chk("t4_dvalid_count", 32'(dv_cnt - s_dv), 32'd1);
        div = 1;

        // Back-to-back frames
        snap;
        frame(4'b1011, 1'b0, 1'b1);
        chk("t5_first_dout", 32'(dout), 32'hb);
        frame(4'b0000, 1'b0, 1'b1);
        chk("t5_gap", 32'(dv_gap), 32'd7);
        chk("t5_dout", 32'(dout), 32'h0);
        chk("t5_dvalid_count", 32'(dv_cnt - s_dv), 32'd2);
        idle(1);

        // Reset after the 2nd data bit
        frame(4'b1001, 1'b0, 1'b1);
        snap;
        sbit(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        sbit(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        sbit(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        do_reset;
        idle(8);
        chk("t6_no_pulse", 32'((dv_cnt - s_dv) + (fe_cnt - s_fe) + (pe_cnt - s_pe)), 32'd0);
        chk("t6_dout_cleared", 32'(dout), 32'h0);
        frame(4'b1110, 1'b0, 1'b1);
        idle(1);
        chk("t6_clean_dout", 32'(dout), 32'he);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/serial_frame_rx.md
# serial_frame_rx

- Deserializing receiver that sits directly downstream of the 4-bit shift-register stages (PISO/SISO serial output).
- Hunts for a start bit on a serial line, shifts in `WIDTH` data bits LSB first, then checks an optional even-parity bit and a stop bit.
- Presents the assembled word on a parallel output with a one-cycle valid strobe, and flags framing or parity errors.
- Sampling is gated by a bit-enable strobe, so one design serves both one-bit-per-clock links and slower links.

## Interface
- `WIDTH`, default 4: data bits per frame; legal range 2..16.
- `PARITY_EN`, default 1: 1 = an even-parity bit follows the data bits; 0 = no parity bit.
- `clk` input, 1 bit: single clock; all logic is on the rising edge.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `sin` input, 1 bit: serial line; idles high.
- `en` input, 1 bit: bit strobe; `sin` is sampled only on edges where `en`=1.
- `dout` output, `WIDTH` bits: last good received word, LSB = first data bit received.
- `dvalid` output, 1 bit: one-cycle pulse; `dout` holds a new word.
- `ferr` output, 1 bit: one-cycle pulse; the stop bit was sampled 0.
- `perr` output, 1 bit: one-cycle pulse; parity mismatch with a good stop bit.
- `busy` output, 1 bit: high while a frame is in progress (any state other than IDLE and HUNT).

## Operation
- States: IDLE, DATA, PARITY, STOP, HUNT.
- With `en`=0, state, counter, shift register and `dout` all hold. `dvalid`, `ferr` and `perr` are 0 on every edge where `en`=0.
- IDLE: `sin`=0 sampled → DATA, bit counter cleared. `sin`=1 → stay in IDLE.
- DATA: shift `sin` into the shift register at the MSB end, shifting right, so the first bit ends at the LSB. Update the running XOR. After the `WIDTH`-th data bit → PARITY if `PARITY_EN`, else STOP.
- PARITY: latch the expected-parity check (running XOR of data bits XOR `sin` must be 0, i.e. even parity) → STOP.
- STOP, `sin`=1 and parity OK (or `PARITY_EN`=0): `dout` ← shift register, `dvalid`=1 → IDLE.
- STOP, `sin`=1 and parity bad: `perr`=1, `dout` unchanged → IDLE.
- STOP, `sin`=0: `ferr`=1, `dout` unchanged, parity result ignored → HUNT.
- HUNT: wait until `sin`=1 is sampled → IDLE. A held-low line (break) therefore produces exactly one `ferr` and no false frames.
- Frame length in `en` samples: 1 + `WIDTH` + `PARITY_EN` + 1.
- Back-to-back frames are legal: the next start bit may arrive on the `en` sample immediately after the stop bit.

## Timing
- `rst`=1 at an edge: state → IDLE; `dout`=0; `dvalid`, `ferr`, `perr` and `busy` = 0; counter and shift register cleared.
- A reset mid-frame aborts the frame with no pulses. `rst` has priority over `en`.
- All outputs are registered. `dvalid`, `ferr` and `perr` go high after the edge that samples the stop bit and stay high exactly one `clk` cycle.
- At most one of `dvalid`, `ferr` and `perr` is high in any cycle.
- `busy` goes high after the edge that samples the start bit. It goes low after the edge that samples the stop bit.
- With `en` tied high, `WIDTH`=4 and `PARITY_EN`=1, `dvalid` rises 7 edges after the start-bit edge is sampled; the start-bit sample counts as edge 1.
- `dout` is stable between `dvalid` pulses.

## Test plan
- Good frame, `en`=1, WIDTH=4, parity on. `sin` sequence 0,1,1,0,1,1,1 (start, data 1011 sent LSB first, parity 1, stop). Required: `dout`=4'b1011, one `dvalid` pulse, `busy` high for 6 cycles.
- Parity error: same sequence with parity bit 0. Required: `perr` pulses, `dvalid`=0, `dout` keeps its previous value (0 after reset).
- Framing error and break: stop bit 0, then `sin` held 0 for 20 cycles, then 1. Required: exactly one `ferr`, no further pulses until a new start bit follows the return to 1.
- Slow strobe: `en` high every 4th `clk` cycle, frame for 4'b0101 (parity 0). Required: `dout`=4'b0101, with `dvalid` a single `clk` cycle wide.
- Back-to-back: frames for 4'b1011 then 4'b0000 with no idle gap. Required: two `dvalid` pulses 7 cycles apart, `dout` = 4'b1011 and then 4'b0000.
- Reset mid-frame: `rst` pulsed after the 2nd data bit. Required: all outputs 0, no pulse. A following clean frame is received correctly.
